// File: rtl/netbus_rx_port_if.sv
// rtl/netbus_rx_port_if.sv - NetBus receive-leg flit bus bundle
//
// Purpose: groups the transmitter-facing input stream (WDATA/WVALID/WREADY)
// and the consumer-facing output stream (DATA/VALID/READY) of one NetBus
// receive port. Flit width W = DATA_WIDTH*9 + 14.
//
// Modports:
//   slave  - the receive port itself: takes WDATA/WVALID/READY,
//            drives WREADY/DATA/VALID.
//   master - the surrounding environment (transmitter + local consumer).

interface netbus_rx_port_if #(
  parameter int DATA_WIDTH = 4
);
  localparam int W = DATA_WIDTH * 9 + 14;

  logic [W-1:0] WDATA;
  logic         WVALID;
  logic         WREADY;
  logic [W-1:0] DATA;
  logic         VALID;
  logic         READY;

  modport slave (
    input  WDATA,
    input  WVALID,
    input  READY,
    output WREADY,
    output DATA,
    output VALID
  );

  modport master (
    output WDATA,
    output WVALID,
    output READY,
    input  WREADY,
    input  DATA,
    input  VALID
  );
endinterface

// File: rtl/netbus_rx_port.sv
// rtl/netbus_rx_port.sv - NetBus broadcast-leg receive endpoint
//
// Purpose: claims flits addressed to NODE_ADDR from the broadcast
// transmitter, buffers them in a show-ahead FIFO, presents them to the
// local consumer, and checks SOP/EOP framing.
//
// Ports:
//   CLK      in   clock, rising edge
//   RESETN   in   asynchronous active-low reset
//   bus      slave modport of netbus_rx_port_if
//            WDATA/WVALID in, WREADY out  - transmitter side
//            DATA/VALID out, READY in     - local consumer side
//   ERR      out  sticky framing-error flag
//   PKT_CNT  out  accepted EOP flit count, wraps at 16 bits
//
// Flit layout: [7:0] DEST, [8] SOP, [9] EOP, [13:10] VLEN, [W-1:14] payload.

module netbus_rx_port #(
  parameter int         DATA_WIDTH = 4,
  parameter logic [7:0] NODE_ADDR  = 8'h00,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic           CLK,
  input  logic           RESETN,
  netbus_rx_port_if.slave bus,
  output logic           ERR,
  output logic [15:0]    PKT_CNT
);

  localparam int W  = DATA_WIDTH * 9 + 14;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [W-1:0]  mem_q [FIFO_DEPTH];
  logic [W-1:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic          err_q, err_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;

  // ------------------------------------------------------------------
  // Handshake decode
  // ------------------------------------------------------------------
  logic match;
  logic full;
  logic empty;
  logic wready;
  logic in_xfer;
  logic out_xfer;
  logic flit_sop;
  logic flit_eop;

  assign match    = (bus.WDATA[7:0] == NODE_ADDR);
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  // WREADY is independent of WVALID so the transmitter's OR of all legs'
  // READY only ever reflects the addressed node.
  assign wready   = match & ~full;
  assign in_xfer  = bus.WVALID & wready;
  assign out_xfer = ~empty & bus.READY;
  assign flit_sop = bus.WDATA[8];
  assign flit_eop = bus.WDATA[9];

  assign bus.WREADY = wready;
  assign bus.VALID  = ~empty;
  assign bus.DATA   = mem_q[rd_ptr_q];
  assign ERR        = err_q;
  assign PKT_CNT    = pkt_cnt_q;

  // ------------------------------------------------------------------
  // Framing FSM: decides whether an accepted flit is stored, and
  // updates the error flag and packet counter.
  // ------------------------------------------------------------------
  logic push;
  logic pkt_inc;
  logic err_set;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pkt_inc = 1'b0;
    err_set = 1'b0;

    if (in_xfer) begin
      unique case (state_q)
        IDLE: begin
          if (flit_sop) begin
            push = 1'b1;
            if (flit_eop) begin
              pkt_inc = 1'b1;
            end else begin
              state_d = IN_PKT;
            end
          end else begin
            // Orphan continuation flit: swallowed so the transmitter is
            // not stalled, but never forwarded.
            err_set = 1'b1;
          end
        end
        IN_PKT: begin
          // A SOP here truncates the open packet; the new flit is kept and
          // starts the next packet, so the next state depends only on EOP.
          push    = 1'b1;
          err_set = flit_sop;
          if (flit_eop) begin
            pkt_inc = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // FIFO bookkeeping
  // ------------------------------------------------------------------
  logic pop;
  assign pop = out_xfer;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = bus.WDATA;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    err_d     = err_q | err_set;
    pkt_cnt_d = pkt_inc ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      err_q     <= 1'b0;
      pkt_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      err_q     <= err_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: doc/netbus_rx_port.md
Name: netbus_rx_port

Overview:
- Receive endpoint on one NetBus broadcast leg; sits directly downstream of the 4-way broadcast transmitter.
- Consumes WDATA/WVALID and drives WREADY. Claims only flits whose destination field matches this node, so the transmitter's OR-combined READY reflects the addressed node only.
- Accepted flits are buffered in a small show-ahead FIFO and presented to the local consumer on a VALID/READY interface.
- Tracks SOP/EOP framing and flags malformed packets.

Parameters:
- DATA_WIDTH, 4, number of 9-bit payload lanes; flit width W = DATA_WIDTH*9+14.
- NODE_ADDR, 8'h00, destination address this port answers to.
- FIFO_DEPTH, 4, flit buffer depth; power of two, minimum 2.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RESETN  in  1  reset, asynchronous assert, active-low.
- WDATA  in  W  flit from transmitter. [7:0] DEST, [8] SOP, [9] EOP, [13:10] VLEN (valid lanes), [W-1:14] payload lanes.
- WVALID  in  1  flit valid.
- WREADY  out  1  this port accepts the current flit.
- DATA  out  W  head-of-FIFO flit, unmodified.
- VALID  out  1  FIFO non-empty.
- READY  in  1  local consumer accepts DATA.
- ERR  out  1  sticky framing-error flag.
- PKT_CNT  out  16  count of accepted EOP flits; wraps 16'hFFFF -> 0.

Behaviour:
- Address match: match = (WDATA[7:0] == NODE_ADDR). No broadcast address exists.
- WREADY = match & ~full. Combinational from WDATA and FIFO state; does not depend on WVALID.
  - Non-matching flits leave WREADY low. Such flits are never stored and never affect the FSM.
- Input transfer: WVALID & WREADY at a rising edge.
- Output transfer: VALID & READY at a rising edge. DATA is valid whenever VALID = 1 (show-ahead).
- Latency: a flit accepted at edge N appears on DATA with VALID = 1 after edge N (one cycle). There is no bypass path.
- Full handling: at count == FIFO_DEPTH, WREADY = 0 even if a pop occurs in the same cycle (no full pass-through).
- Simultaneous push and pop when count is 1..DEPTH-1: count unchanged, order preserved.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count register is one bit wider.
- Framing FSM (updated only on input transfers):
  - IDLE:
    - SOP&EOP: push, PKT_CNT++, stay IDLE.
    - SOP&~EOP: push, go to IN_PKT.
    - ~SOP: flit is consumed (WREADY high) but not pushed; ERR <= 1; stay IDLE.
  - IN_PKT:
    - ~SOP&~EOP: push, stay.
    - ~SOP&EOP: push, PKT_CNT++, go to IDLE.
    - SOP: push; ERR <= 1; treated as the start of a new packet (IN_PKT, or IDLE with PKT_CNT++ if EOP is also set). Flits of the truncated packet already in the FIFO remain.
- VLEN is passed through untouched and not checked.
- ERR stays set until reset.
- Reset (asynchronous, any time, including mid-packet):
  - FIFO emptied; VALID = 0; WREADY = match (FIFO empty).
  - ERR = 0, PKT_CNT = 0, FSM = IDLE.
  - Flits in flight are lost.

Test Plan:
- Reset, NODE_ADDR = 8'h05, drive a single-flit packet DEST = 05, SOP = 1, EOP = 1, payload 36'hA5A5A5A5A with READY = 1 -> WREADY = 1. One cycle later VALID = 1 with identical DATA. PKT_CNT = 1, ERR = 0.
- Flit with DEST = 8'h06, WVALID = 1 held 5 cycles -> WREADY = 0 throughout, VALID stays 0, PKT_CNT = 0.
- READY = 0, push a 6-flit packet to DEST 05 (SOP on flit 0, EOP on flit 5) -> WREADY drops after 4 accepts. Raise READY: flits drain in order 0..5, WREADY reasserts once count < 4, PKT_CNT = 1 after the EOP accept.
- Stream with push and pop every cycle at count = 2 for 10 cycles -> count stays 2, output order equals input order, no WREADY drop.
- Malformed framing: in IDLE, send a DEST = 05 flit with SOP = 0 -> accepted, not output, ERR = 1. Then send SOP, SOP, EOP -> all 3 output, PKT_CNT = 1, ERR still 1.
- Assert RESETN = 0 mid-packet with 3 flits buffered -> VALID = 0, ERR = 0, PKT_CNT = 0 immediately. After release, a new single-flit packet is delivered normally with PKT_CNT = 1.
